// File: rtl/sincos_pkg.sv
// Shared definitions for the sine/cosine phase detector and related CORDIC
// blocks: FSM state type, quadrant angle constants and the arctangent table.
package sincos_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREROT = 2'd1,
    ROTATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Quadrant multipliers; one quadrant is 2^(phase_w-2) binary angle units.
  localparam int QUAD_0   = 0;
  localparam int QUAD_90  = 1;
  localparam int QUAD_180 = 2;
  localparam int QUAD_270 = 3;

  // Angle of a whole number of quadrants, in units where 2^phase_w = one turn.
  function automatic logic [63:0] quadrant_angle(input int phase_w, input int quadrant);
    return 64'(quadrant) << (phase_w - 2);
  endfunction

  // atan(2^-idx) expressed as a fraction of a turn, scaled by 2^32.
  // For idx >= 10 atan(x) equals x to well below one unit of this scale,
  // so the tail is taken as 2^32/(2*pi) * 2^-idx.
  function automatic logic [31:0] atan_turn32(input int idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'd536870912;
      1:       v = 32'd316933406;
      2:       v = 32'd167458907;
      3:       v = 32'd85004756;
      4:       v = 32'd42667331;
      5:       v = 32'd21354465;
      6:       v = 32'd10679838;
      7:       v = 32'd5340245;
      8:       v = 32'd2670163;
      9:       v = 32'd1335087;
      default: v = (idx > 40) ? 32'd0 : 32'(64'd683565276 >> idx);
    endcase
    return v;
  endfunction

  // round(atan(2^-idx) * 2^phase_w / (2*pi)); valid for phase_w up to 32.
  function automatic logic [31:0] atan_angle(input int phase_w, input int idx);
    logic [63:0] full;
    logic [63:0] half;
    full = {32'd0, atan_turn32(idx)};
    if (phase_w >= 32) begin
      return full[31:0];
    end
    half = 64'd1 << (31 - phase_w);
    return 32'((full + half) >> (32 - phase_w));
  endfunction

endpackage

// File: rtl/sincos_atan_rom.sv
// Combinational arctangent lookup: micro-rotation index -> angle step in
// binary angle units. Kept separate so a rotation-mode CORDIC can reuse it.
module sincos_atan_rom
  import sincos_pkg::*;
#(
  parameter int PHASE_W = 8,
  parameter int ITER    = 8,
  localparam int IDX_W  = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [PHASE_W-1:0] angle
);

  localparam int DEPTH = 1 << IDX_W;

  logic [PHASE_W-1:0] rom_w [DEPTH];

  // Table contents are elaboration-time constants; unused slots read as zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    if (gi < ITER) begin : g_used
      assign rom_w[gi] = PHASE_W'(atan_angle(PHASE_W, gi));
    end else begin : g_unused
      assign rom_w[gi] = '0;
    end
  end

  assign angle = rom_w[idx];

endmodule

// File: rtl/sincos_phase_detect.sv
// Iterative CORDIC vectoring engine: converts one signed (sine, cos) pair
// into a binary phase angle and a vector magnitude.
// Optional build macro: SINCOS_PHASE_GAIN_COMP_EN scales mag by ~1/K so it
// approximates the true radius instead of the raw CORDIC-gained value.
module sincos_phase_detect
  import sincos_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PHASE_W = 8,
  parameter int ITER    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] sine_in,
  input  logic signed [WIDTH-1:0] cos_in,
  output logic                    busy,
  output logic                    done,
  output logic [PHASE_W-1:0]      phase,
  output logic [WIDTH:0]          mag
);

  // Two guard bits: one for negating -2^(WIDTH-1), one for CORDIC growth.
  localparam int XW    = WIDTH + 2;
  localparam int IDX_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(ITER - 1);
  localparam logic [PHASE_W-1:0] ANG_90  = PHASE_W'(quadrant_angle(PHASE_W, QUAD_90));
  localparam logic [PHASE_W-1:0] ANG_270 = PHASE_W'(quadrant_angle(PHASE_W, QUAD_270));

  state_e                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic signed [XW-1:0]  y_q, y_d;
  logic [PHASE_W-1:0]    z_q, z_d;
  logic [IDX_W-1:0]      iter_q, iter_d;
  logic                  zero_q, zero_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [WIDTH:0]        mag_q, mag_d;

  logic signed [XW-1:0]  x_sh_w;
  logic signed [XW-1:0]  y_sh_w;
  logic [PHASE_W-1:0]    atan_w;
  logic [WIDTH:0]        mag_w;

  sincos_atan_rom #(
    .PHASE_W (PHASE_W),
    .ITER    (ITER)
  ) u_atan_rom (
    .idx   (iter_q),
    .angle (atan_w)
  );

  // Arithmetic shifts by the current micro-rotation index.
  assign x_sh_w = x_q >>> iter_q;
  assign y_sh_w = y_q >>> iter_q;

`ifdef SINCOS_PHASE_GAIN_COMP_EN
  // 1/K ~= 1/2 + 1/8 - 1/64 - 1/512; x is non-negative once rotation ends.
  assign mag_w = (WIDTH+1)'((x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9));
`else
  assign mag_w = x_q[WIDTH:0];
`endif

  // Next-state, datapath and output computation for the conversion sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    phase_d = phase_q;
    mag_d   = mag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = {{2{cos_in[WIDTH-1]}}, cos_in};
          y_d     = {{2{sine_in[WIDTH-1]}}, sine_in};
          z_d     = '0;
          iter_d  = '0;
          // A null vector has no direction; it is reported as angle 0.
          zero_d  = (sine_in == '0) && (cos_in == '0);
          busy_d  = 1'b1;
          state_d = PREROT;
        end
      end

      PREROT: begin
        // Fold the vector into the right half-plane so rotation converges.
        if (!x_q[XW-1]) begin
          z_d = '0;
        end else if (!y_q[XW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = ANG_90;
        end else begin
          x_d = -y_q;
          y_d = x_q;
          z_d = ANG_270;
        end
        state_d = ROTATE;
      end

      ROTATE: begin
        // Rotate towards the +X axis; both updates use the pre-update x and y.
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh_w;
          y_d = y_q - x_sh_w;
          z_d = z_q + atan_w;
        end else begin
          x_d = x_q - y_sh_w;
          y_d = y_q + x_sh_w;
          z_d = z_q - atan_w;
        end
        if (iter_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end

      DONE: begin
        phase_d = zero_q ? '0 : z_q;
        mag_d   = mag_w;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign phase = phase_q;
  assign mag   = mag_q;

endmodule

// File: tb/tb_sincos_phase_detect.sv
// Self-checking bench for sincos_phase_detect: directed quadrant/boundary
// vectors, an oscillator sweep, random vectors, back-to-back starts and reset abort.
module tb_sincos_phase_detect;

  localparam int WIDTH   = 8;
  localparam int PHASE_W = 8;
  localparam int ITER    = 8;
  localparam int FULL    = 1 << PHASE_W;
  localparam int PERIOD  = ITER + 3;
  localparam int LAT     = ITER + 2;
  localparam real PI     = 3.14159265358979;
  localparam real KGAIN  = 1.6467602581;
  localparam int PH_TOL  = 5;
  localparam int MAG_TOL = 5;
  localparam int OSC_STEP = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic signed [WIDTH-1:0] sine_in = '0;
  logic signed [WIDTH-1:0] cos_in = '0;
  logic                    busy;
  logic                    done;
  logic [PHASE_W-1:0]      phase;
  logic [WIDTH:0]          mag;

  int n_checks = 0;
  int n_fail   = 0;

  sincos_phase_detect #(
    .WIDTH   (WIDTH),
    .PHASE_W (PHASE_W),
    .ITER    (ITER)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sine_in (sine_in),
    .cos_in  (cos_in),
    .busy    (busy),
    .done    (done),
    .phase   (phase),
    .mag     (mag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: quadrant fold followed by ITER shift-add micro-rotations on
  // plain integers, with the arctangent steps computed from real arithmetic.
  function automatic void ref_model(input int s, input int c, output int ph, output int mg);
    int x, y, z, xo, yo, ang, mval;
    if (s == 0 && c == 0) begin
      ph = 0;
      mg = 0;
      return;
    end
    if (c >= 0) begin
      x = c;  y = s;  z = 0;
    end else if (s >= 0) begin
      x = s;  y = -c; z = FULL / 4;
    end else begin
      x = -s; y = c;  z = 3 * FULL / 4;
    end
    for (int i = 0; i < ITER; i++) begin
      ang = $rtoi($floor($atan(1.0 / real'(1 << i)) * real'(FULL) / (2.0 * PI) + 0.5));
      xo = x;
      yo = y;
      if (yo >= 0) begin
        x = xo + (yo >>> i);
        y = yo - (xo >>> i);
        z = z + ang;
      end else begin
        x = xo - (yo >>> i);
        y = yo + (xo >>> i);
        z = z - ang;
      end
    end
    ph = z & (FULL - 1);
`ifdef SINCOS_PHASE_GAIN_COMP_EN
    mval = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`else
    mval = x;
`endif
    mg = mval & ((1 << (WIDTH + 1)) - 1);
  endfunction

  // Circular distance between an observed angle and a reference angle.
  function automatic real ang_dist(input int got, input real ref_ang);
    real d;
    d = real'(got) - ref_ang;
    while (d >= real'(FULL) / 2.0) d = d - real'(FULL);
    while (d < -real'(FULL) / 2.0) d = d + real'(FULL);
    return (d < 0.0) ? -d : d;
  endfunction

  // Accuracy against the exact polar form, for vectors large enough to resolve.
  task automatic check_ideal(input string tag, input int s, input int c);
    real r, a, ideal_mag, dp, dm;
    r = $sqrt(real'(s * s + c * c));
    if (r < 64.0) return;
    a = $atan2(real'(s), real'(c));
    if (a < 0.0) a = a + 2.0 * PI;
    dp = ang_dist(int'(phase), a * real'(FULL) / (2.0 * PI));
`ifdef SINCOS_PHASE_GAIN_COMP_EN
    ideal_mag = r * KGAIN * 0.607421875;
`else
    ideal_mag = r * KGAIN;
`endif
    dm = real'(mag) - ideal_mag;
    if (dm < 0.0) dm = -dm;
    check_eq({tag, "_phase_err"}, (dp > real'(PH_TOL)) ? longint'($ceil(dp)) : 0, 0);
    check_eq({tag, "_mag_err"}, (dm > real'(MAG_TOL)) ? longint'($ceil(dm)) : 0, 0);
  endtask

  // One full conversion: latency, busy, result against the model, hold after done.
  task automatic run_conv(input string tag, input int s, input int c);
    int n, eph, emg;
    bit busy_dropped;
    ref_model(s, c, eph, emg);
    sine_in = WIDTH'(s);
    cos_in  = WIDTH'(c);
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy_on"}, busy, 1);
    n = 0;
    busy_dropped = 1'b0;
    while (n < 64) begin
      tick();
      n++;
      if (done) break;
      if (!busy) busy_dropped = 1'b1;
    end
    check_eq({tag, "_done_seen"}, done, 1);
    check_eq({tag, "_latency"}, n, LAT);
    check_eq({tag, "_busy_gap"}, busy_dropped, 0);
    check_eq({tag, "_busy_off"}, busy, 0);
    check_eq({tag, "_phase"}, phase, eph);
    check_eq({tag, "_mag"}, mag, emg);
    check_ideal(tag, s, c);
    $display("conv %s sine=%0d cos=%0d phase=%0d mag=%0d lat=%0d", tag, s, c, phase, mag, n);
    tick();
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_phase_hold"}, phase, eph);
  endtask

  int dir_s [7] = '{0, 120, 0, -120, -85, -128, 0};
  int dir_c [7] = '{120, 0, -120, 0, 85, -128, 0};
  int dir_p [7] = '{0, 64, 128, 192, 224, 160, 0};

  int tp_s [4*PERIOD];
  int tp_c [4*PERIOD];

  initial begin
    int s, c, prev_ph, dev, n_done, acc, eph, emg;
    real th;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_mag", mag, 0);
    reset = 1'b0;
    tick();

    // Axis, diagonal, full-scale negative corner and null vector.
    for (int i = 0; i < 7; i++) begin
      run_conv($sformatf("dir%0d", i), dir_s[i], dir_c[i]);
      check_eq($sformatf("dir%0d_plan_dev", i),
               (ang_dist(int'(phase), real'(dir_p[i])) > real'(PH_TOL)) ? longint'(phase) : dir_p[i],
               dir_p[i]);
    end
    check_eq("zero_mag", mag, 0);

    // Oscillator sweep: phase advances by a constant step modulo one turn.
    prev_ph = 0;
    for (int k = 0; k < 200; k++) begin
      th = 2.0 * PI * real'(k * OSC_STEP + 3) / real'(FULL);
      s = $rtoi($floor(120.0 * $sin(th) + 0.5));
      c = $rtoi($floor(120.0 * $cos(th) + 0.5));
      run_conv("osc", s, c);
      if (k > 0) begin
        dev = ((int'(phase) - prev_ph) & (FULL - 1)) - OSC_STEP;
        check_eq("osc_step_dev", (dev > 2 * PH_TOL || dev < -2 * PH_TOL) ? dev : 0, 0);
      end
      prev_ph = int'(phase);
    end

    // Random vectors over the full input range.
    for (int k = 0; k < 100; k++) begin
      s = int'($urandom_range(0, 255)) - 128;
      c = int'($urandom_range(0, 255)) - 128;
      run_conv("rnd", s, c);
    end

    // start held high with new data every cycle: only IDLE starts count.
    n_done = 0;
    for (int e = 0; e < 4 * PERIOD; e++) begin
      tp_s[e] = int'($urandom_range(0, 255)) - 128;
      tp_c[e] = int'($urandom_range(0, 255)) - 128;
      sine_in = WIDTH'(tp_s[e]);
      cos_in  = WIDTH'(tp_c[e]);
      start   = 1'b1;
      tick();
      if (done) begin
        check_eq("tp_done_edge", e, n_done * PERIOD + LAT);
        acc = e - LAT;
        if (acc < 0) acc = 0;
        ref_model(tp_s[acc], tp_c[acc], eph, emg);
        check_eq("tp_phase", phase, eph);
        check_eq("tp_mag", mag, emg);
        $display("tp done edge=%0d sine=%0d cos=%0d phase=%0d mag=%0d", e, tp_s[acc], tp_c[acc], phase, mag);
        n_done++;
      end
    end
    start = 1'b0;
    check_eq("tp_done_count", n_done, 4);
    repeat (PERIOD) tick();

    // Reset in the middle of ROTATE aborts without a done pulse.
    sine_in = WIDTH'(70);
    cos_in  = WIDTH'(-90);
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_eq("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_phase", phase, 0);
    check_eq("abort_mag", mag, 0);
    n_done = 0;
    for (int k = 0; k < ITER + 4; k++) begin
      tick();
      if (done || busy) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    $display("abort reset mid-rotate busy=%0d phase=%0d mag=%0d", busy, phase, mag);

    // Engine still works after the abort.
    run_conv("post_abort", 100, 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
